// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared encodings, op/state enums and decode for the ALU + M-extension unit
package alu_mdu_pkg;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;
  // M ops are kept contiguous and in funct3 order so decode can offset from FN_MUL
  typedef enum logic [4:0] {
    FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND,
    FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_DIV, FN_DIVU, FN_REM, FN_REMU
  } alu_fn_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
  function automatic alu_fn_e decode(input logic [1:0] op, input logic [2:0] f3,
                                     input logic f7b5, input logic f7b0);
    if (op == ALU_ADD) return FN_ADD;
    if (op == ALU_SUB) return FN_SUB;
    if (op == ALU_RTYPE && f7b0) return alu_fn_e'(FN_MUL + 5'(f3));
    case (f3)
      3'b000:  return (f7b5 && op == ALU_RTYPE) ? FN_SUB : FN_ADD;
      3'b001:  return FN_SLL;
      3'b010:  return FN_SLT;
      3'b011:  return FN_SLTU;
      3'b100:  return FN_XOR;
      3'b101:  return f7b5 ? FN_SRA : FN_SRL;
      3'b110:  return FN_OR;
      default: return FN_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response handshake bundle between the controller and alu_mdu_unit
interface alu_mdu_if #(parameter int XLEN = 32);
  logic            flush, in_valid, in_ready, funct7b5, funct7b0;
  logic            out_valid, out_ready, illegal, busy;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, result;
  modport master (output flush, in_valid, alu_op, funct3, funct7b5, funct7b0, op_a, op_b, out_ready,
                  input in_ready, out_valid, result, illegal, busy);
  modport slave  (input flush, in_valid, alu_op, funct3, funct7b5, funct7b0, op_a, op_b, out_ready,
                  output in_ready, out_valid, result, illegal, busy);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: unsigned shift-add multiply / restoring divide, one step per cycle
module mdu_iter #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_last
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] r_hi, r_lo, r_b, w_diff;
  logic [XLEN:0]   w_sum, w_sh;
  logic [CW-1:0]   r_cnt;
  logic            r_div, w_lt;
  // hi:lo is product high:low for multiply and remainder:quotient for divide
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_lt   = w_sh < {1'b0, r_b};
  assign w_diff = w_sh[XLEN-1:0] - r_b;
  assign o_hi   = r_div ? (w_lt ? w_sh[XLEN-1:0] : w_diff) : w_sum[XLEN:1];
  assign o_lo   = r_div ? {r_lo[XLEN-2:0], !w_lt} : {w_sum[0], r_lo[XLEN-1:1]};
  assign o_last = r_cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_div;
      r_cnt <= CW'(XLEN - 1);
    end else if (i_step) begin
      r_hi  <= o_hi;
      r_lo  <= o_lo;
      r_cnt <= o_last ? r_cnt : r_cnt - 1'b1;
    end
endmodule

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: decoded single-cycle ALU plus iterative RV M-extension unit with a
// registered valid/ready result
module alu_mdu_unit
  import alu_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input logic        clk,
  input logic        rst_n,
  alu_mdu_if.slave   bus
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_e        r_state;
  alu_fn_e           r_fn, w_fn;
  logic              r_neg, r_out_valid, r_illegal;
  logic [XLEN-1:0]   r_result, w_alu, w_abs_a, w_abs_b, w_spec, w_fast, w_hi, w_lo, w_q, w_r, w_mdu;
  logic [2*XLEN-1:0] w_prod;
  logic              w_m, w_div, w_rem, w_neg_a, w_neg_b, w_dz, w_ovf, w_ill, w_iter;
  logic              w_load, w_step, w_last;
  logic [SW-1:0]     w_sh;
  assign w_fn    = decode(bus.alu_op, bus.funct3, bus.funct7b5, bus.funct7b0);
  assign w_m     = w_fn >= FN_MUL;
  assign w_div   = w_fn >= FN_DIV;
  assign w_rem   = w_fn >= FN_REM;
  assign w_neg_a = (w_fn inside {FN_MULH, FN_MULHSU, FN_DIV, FN_REM}) && bus.op_a[XLEN-1];
  assign w_neg_b = (w_fn inside {FN_MULH, FN_DIV, FN_REM}) && bus.op_b[XLEN-1];
  assign w_abs_a = w_neg_a ? -bus.op_a : bus.op_a;
  assign w_abs_b = w_neg_b ? -bus.op_b : bus.op_b;
  assign w_dz    = w_div && bus.op_b == '0;
  assign w_ovf   = (w_fn == FN_DIV || w_fn == FN_REM) && bus.op_a == MIN && &bus.op_b;
  assign w_ill   = w_m && MUL_EN == 0;
  assign w_iter  = w_m && !w_dz && !w_ovf && !w_ill;
  assign w_spec  = w_dz ? (w_rem ? bus.op_a : '1) : (w_rem ? '0 : MIN);
  assign w_fast  = w_ill ? '0 : (w_dz || w_ovf) ? w_spec : w_alu;
  assign w_sh    = bus.op_b[SW-1:0];
  always_comb begin
    w_alu = '0;
    case (w_fn)
      FN_ADD:  w_alu = bus.op_a + bus.op_b;
      FN_SUB:  w_alu = bus.op_a - bus.op_b;
      FN_SLL:  w_alu = bus.op_a << w_sh;
      FN_SLT:  w_alu = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      FN_SLTU: w_alu = XLEN'(bus.op_a < bus.op_b);
      FN_XOR:  w_alu = bus.op_a ^ bus.op_b;
      FN_SRL:  w_alu = bus.op_a >> w_sh;
      FN_SRA:  w_alu = $signed(bus.op_a) >>> w_sh;
      FN_OR:   w_alu = bus.op_a | bus.op_b;
      FN_AND:  w_alu = bus.op_a & bus.op_b;
      default: w_alu = '0;
    endcase
  end
  assign w_load = bus.in_valid && r_state == IDLE && w_iter && !bus.flush;
  assign w_step = r_state == CALC && !bus.flush;
  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk, .rst_n, .i_load(w_load), .i_step(w_step), .i_div(w_div),
    .i_a(w_abs_a), .i_b(w_abs_b), .o_hi(w_hi), .o_lo(w_lo), .o_last(w_last)
  );
  // sign correction is taken from the final step's outputs as the result register loads
  assign w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
  assign w_q    = r_neg ? -w_lo : w_lo;
  assign w_r    = r_neg ? -w_hi : w_hi;
  assign w_mdu  = r_fn == FN_MUL ? w_prod[XLEN-1:0] : r_fn < FN_DIV ? w_prod[2*XLEN-1:XLEN] :
                  r_fn >= FN_REM ? w_r : w_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_fn        <= FN_ADD;
      r_neg       <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_fn        <= w_fn;
          r_neg       <= w_rem ? w_neg_a : w_neg_a ^ w_neg_b;
          r_illegal   <= w_ill;
          r_state     <= w_iter ? CALC : DONE;
          r_out_valid <= !w_iter;
          if (!w_iter) r_result <= w_fast;
        end
        CALC: if (w_last) begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_mdu;
        end
        DONE: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.in_ready  = r_state == IDLE;
  assign bus.busy      = r_state == CALC;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: directed and random checks of alu_mdu_unit against an arithmetic reference model
module tb_alu_mdu_unit;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  int total = 0, bad = 0;
  alu_mdu_if #(.XLEN(32)) b0 ();
  alu_mdu_if #(.XLEN(32)) b1 ();
  alu_mdu_unit #(.XLEN(32), .MUL_EN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  alu_mdu_unit #(.XLEN(32), .MUL_EN(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                                        input logic f0, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = a == MIN && b == 32'hFFFF_FFFF;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b10 && f0) begin
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * ub; return p[63:32]; end
        3'd3: begin p = ua * ub; return p[63:32]; end
        3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? MIN : 32'(sa / sb);
        3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
        3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
        default: return b == 0 ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (op == 2'b10 && f5) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, sa < sb};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f5 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f5, input logic f0,
                       input logic [31:0] a, input logic [31:0] b);
    b0.alu_op = op; b0.funct3 = f3; b0.funct7b5 = f5; b0.funct7b0 = f0;
    b0.op_a = a; b0.op_b = b; b0.in_valid = 1'b1;
  endtask
  task automatic run(input logic [1:0] op, input logic [2:0] f3, input logic f5, input logic f0,
                     input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    logic [31:0] exp;
    int lat, bz, elat;
    exp = model(op, f3, f5, f0, a, b);
    elat = (op == 2'b10 && f0 && b != 0 && !((f3 == 3'd4 || f3 == 3'd6) && a == MIN && b == 32'hFFFF_FFFF)) ? 33 : 1;
    @(negedge clk);
    chk($sformatf("%s in_ready", tag), b0.in_ready, 1);
    drive(op, f3, f5, f0, a, b);
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.op_a = $urandom; b0.op_b = $urandom; b0.funct3 = 3'($urandom); b0.alu_op = 2'($urandom);
    lat = 1;
    bz = 0;
    while (b0.out_valid !== 1'b1 && lat < 100) begin
      bz += int'(b0.busy);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s latency", tag), lat, elat);
    chk($sformatf("%s busy_cycles", tag), bz, elat - 1);
    chk($sformatf("%s result", tag), b0.result, exp);
    chk($sformatf("%s illegal", tag), b0.illegal, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s hold_result", tag), b0.result, exp);
      chk($sformatf("%s hold_ready", tag), {b0.in_ready, b0.out_valid}, 2'b01);
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    chk($sformatf("%s drained", tag), {b0.in_ready, b0.out_valid}, 2'b10);
  endtask
  initial begin
    int seen;
    b0.flush = 0; b0.in_valid = 0; b0.out_ready = 0; b0.alu_op = 0; b0.funct3 = 0;
    b0.funct7b5 = 0; b0.funct7b0 = 0; b0.op_a = 0; b0.op_b = 0;
    b1.flush = 0; b1.in_valid = 0; b1.out_ready = 0; b1.alu_op = 0; b1.funct3 = 0;
    b1.funct7b5 = 0; b1.funct7b0 = 0; b1.op_a = 0; b1.op_b = 0;
    #2;
    chk("reset outputs", {b0.in_ready, b0.out_valid, b0.busy, b0.illegal, b0.result}, {4'b1000, 32'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(2'b00, 3'd0, 0, 0, 32'd5, 32'd7, 0, "add");
    run(2'b01, 3'd0, 0, 0, 32'd3, 32'd5, 0, "sub");
    run(2'b10, 3'd5, 1, 0, MIN, 32'h24, 0, "sra");
    run(2'b11, 3'd0, 1, 0, 32'd9, 32'd4, 0, "addi_no_sub");
    run(2'b10, 3'd2, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    run(2'b10, 3'd3, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    run(2'b10, 3'd0, 0, 1, 32'hFFFF_FFFE, 32'd3, 5, "mul");
    run(2'b10, 3'd1, 0, 1, 32'hFFFF_FFFE, 32'd3, 0, "mulh");
    run(2'b10, 3'd2, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, "mulhsu");
    run(2'b10, 3'd3, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run(2'b10, 3'd4, 0, 1, 32'd7, 32'd0, 0, "div0");
    run(2'b10, 3'd6, 0, 1, 32'd7, 32'd0, 0, "rem0");
    run(2'b10, 3'd4, 0, 1, MIN, 32'hFFFF_FFFF, 0, "div_ovf");
    run(2'b10, 3'd6, 0, 1, MIN, 32'hFFFF_FFFF, 0, "rem_ovf");
    run(2'b10, 3'd4, 0, 1, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run(2'b10, 3'd6, 0, 1, 32'hFFFF_FFF9, 32'd2, 3, "rem_neg");
    run(2'b10, 3'd5, 0, 1, 32'hFFFF_FFF9, 32'd2, 0, "divu");
    // flush in the middle of a multiply
    @(negedge clk);
    drive(2'b10, 3'd0, 0, 1, 32'd123, 32'd456);
    @(negedge clk);
    b0.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush pre busy", b0.busy, 1);
    b0.flush = 1'b1;
    @(negedge clk);
    b0.flush = 1'b0;
    chk("flush state", {b0.in_ready, b0.busy, b0.out_valid}, 3'b100);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(b0.out_valid);
    end
    chk("flush no out_valid", seen, 0);
    // a flush on the accept edge discards the request
    drive(2'b00, 3'd0, 0, 0, 32'd1, 32'd1);
    b0.flush = 1'b1;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.flush = 1'b0;
    chk("flush accept", {b0.in_ready, b0.out_valid}, 2'b10);
    run(2'b00, 3'd0, 0, 0, 32'd100, 32'd23, 0, "add_after_flush");
    for (int i = 0; i < 40; i++)
      run(2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, pick(), pick(), 0, $sformatf("rnd%0d", i));
    run(2'b00, 3'd0, 0, 0, 32'd100, 32'd23, 0, "add_before_reset");
    // asynchronous reset mid-CALC
    @(negedge clk);
    drive(2'b10, 3'd4, 0, 1, 32'd1000, 32'd7);
    @(negedge clk);
    b0.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst pre busy", b0.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst mid calc", {b0.in_ready, b0.out_valid, b0.busy, b0.illegal, b0.result}, {4'b1000, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    run(2'b10, 3'd6, 0, 1, 32'd1000, 32'd7, 0, "rem_after_reset");
    // M op rejected when the multiplier is disabled
    @(negedge clk);
    b1.alu_op = 2'b10; b1.funct3 = 3'd0; b1.funct7b0 = 1'b1;
    b1.op_a = 32'hFFFF_FFFE; b1.op_b = 32'd3; b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("illegal mul", {b1.out_valid, b1.illegal, b1.busy, b1.result}, {3'b110, 32'd0});
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    chk("illegal drained", {b1.in_ready, b1.out_valid}, 2'b10);
    b1.funct7b0 = 1'b0; b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("legal add no mul", {b1.out_valid, b1.illegal, b1.result}, {2'b10, 32'd1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
